conv3x3_window: RTL

- Downstream consumer of the 3-row line buffer. Takes one column of three vertically aligned pixels per valid cycle (top, middle, bottom rows).
- Shifts these columns into a 3x3 window and computes a signed 3x3 convolution plus bias, with optional ReLU, through a fixed-latency pipeline.
- Emits one result per interior window position in raster order. A zero-padded 28x28 input yields a 28x28 feature map.

---
 rtl/conv3x3_window.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/conv3x3_window.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_window
// Description : 3x3 sliding-window signed convolution with bias and optional
//               ReLU. Takes one 3-pixel column per valid cycle. Three-stage
//               pipeline (product, sum, activate).
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_window #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int PADDING = 1,
    parameter int OUT_W   = 24,
    parameter int RELU    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_row0,
    input  logic [7:0]       in_row1,
    input  logic [7:0]       in_row2,
    input  logic             wt_we,
    input  logic [3:0]       wt_addr,
    input  logic [15:0]      wt_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int c_TOTAL_W = IMG_W + 2 * PADDING;
    localparam int c_TOTAL_H = IMG_H + 2 * PADDING;
    localparam int c_CW      = $clog2(c_TOTAL_W);
    localparam int c_RW      = $clog2(c_TOTAL_H);
    localparam int c_SW      = 22;

    logic        [7:0]      r_win  [0:2][0:2];
    logic        [7:0]      w_nwin [0:2][0:2];
    logic        [c_CW-1:0] r_col_cnt;
    logic        [c_RW-1:0] r_row_cnt;
    logic signed [7:0]      r_wt   [0:8];
    logic signed [15:0]     r_bias;
    logic signed [16:0]     w_prod [0:8];
    logic signed [16:0]     r_prod [0:8];
    logic                   r_s1_valid;
    logic                   r_s1_last;
    logic signed [c_SW-1:0] w_sum;
    logic signed [c_SW-1:0] r_sum;
    logic                   r_s2_valid;
    logic                   r_s2_last;
    logic signed [c_SW-1:0] w_act;
    logic        [OUT_W-1:0] w_ext;
    logic                   w_col_end;
    logic                   w_row_end;
    logic                   w_fire;
    logic                   w_last;

    assign w_col_end = (r_col_cnt == c_CW'(c_TOTAL_W - 1));
    assign w_row_end = (r_row_cnt == c_RW'(c_TOTAL_H - 1));
    assign w_fire    = in_valid && (r_col_cnt >= c_CW'(2)) && (r_row_cnt >= c_RW'(2));
    assign w_last    = w_fire && w_col_end && w_row_end;

    // Window as it will look after this cycle's column is accepted
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_nwin[r][0] = r_win[r][1];
            w_nwin[r][1] = r_win[r][2];
        end
        w_nwin[0][2] = in_row0;
        w_nwin[1][2] = in_row1;
        w_nwin[2][2] = in_row2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= w_nwin[r][c];
            if (w_col_end) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_row_end ? '0 : r_row_cnt + c_RW'(1);
            end else begin
                r_col_cnt <= r_col_cnt + c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++)
                r_wt[k] <= '0;
            r_bias <= '0;
        end else if (wt_we) begin
            for (int k = 0; k < 9; k++)
                if (wt_addr == 4'(k))
                    r_wt[k] <= wt_data[7:0];
            if (wt_addr == 4'd9)
                r_bias <= wt_data;
        end
    end

    // Pixels are unsigned, so a zero MSB makes them non-negative signed operands
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w_prod[r*3+c] = $signed({9'b0, w_nwin[r][c]})
                              * $signed({{9{r_wt[r*3+c][7]}}, r_wt[r*3+c]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++)
                r_prod[k] <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            for (int k = 0; k < 9; k++)
                r_prod[k] <= w_prod[k];
            r_s1_valid <= w_fire;
            r_s1_last  <= w_last;
        end
    end

    always_comb begin
        w_sum = {{6{r_bias[15]}}, r_bias};
        for (int k = 0; k < 9; k++)
            w_sum = w_sum + {{5{r_prod[k][16]}}, r_prod[k]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_sum      <= w_sum;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
        end
    end

    assign w_act = ((RELU != 0) && r_sum[c_SW-1]) ? '0 : r_sum;

    generate
        if (OUT_W > c_SW) begin : g_sext
            assign w_ext = {{(OUT_W - c_SW){w_act[c_SW-1]}}, w_act};
        end else begin : g_nosext
            assign w_ext = w_act[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= r_s2_valid;
            out_last  <= r_s2_valid && r_s2_last;
            if (r_s2_valid)
                out_data <= w_ext;
        end
    end

endmodule
`default_nettype wire
